mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder on the processor data bus. It is the target side of the processor's load/store port traffic.
- Owns the 32-bit PortOut register and samples the 8-bit PortIn through a synchronizer.
- Latches sticky rising-edge flags and counts edge events.
- Answers reads with a registered one-cycle-latency read-valid handshake; writes complete in the cycle they are presented.

---
 rtl/mmio_port_responder.sv | 175 +++++++++++++++++
 tb/tb_mmio_port_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_responder.sv
// -----------------------------------------------------------------------------
// mmio_port_responder
//
// Target-side responder for processor load/store traffic in a 16-byte window.
// Owns the 32-bit output port register, samples an 8-bit asynchronous input
// port through a two-flop synchronizer, latches sticky rising-edge flags and
// counts edge events with a saturating counter.
//
// Register map (word offset Address[3:2]):
//   0x0 OUT   RW    drives PortOut
//   0x4 IN    RO    {24'b0, synchronized PortIn}
//   0x8 EDGE  [7:0] sticky rise flags (W1C), [15:8] EDGE_EN (RW)
//   0xC EVCNT saturating count of cycles with an enabled rise; any write clears
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous, active-low
//   Address    byte address; Address[1:0] ignored (word accesses only)
//   WriteData  store data
//   MemWrite   store strobe; the write lands on the edge it is presented
//   MemRead    load strobe; data returned one cycle later with ReadValid
//   ReadData   registered load data, held between reads
//   ReadValid  one-cycle pulse qualifying ReadData
//   Hit        combinational window decode
//   PortIn     asynchronous external inputs
//   PortOut    OUT register contents
//   EdgeIrq    registered OR of enabled sticky flags
// -----------------------------------------------------------------------------
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        EdgeIrq
);

    typedef enum logic [1:0] {
        REG_OUT   = 2'd0,
        REG_IN    = 2'd1,
        REG_EDGE  = 2'd2,
        REG_EVCNT = 2'd3
    } reg_sel_e;

    logic [31:0]          out_q,    out_d;
    logic [7:0]           sync1_q,  sync2_q;
    logic [7:0]           prev_q,   prev_d;
    logic [1:0]           warm_q,   warm_d;
    logic [7:0]           edge_q,   edge_d;
    logic [7:0]           en_q,     en_d;
    logic [CNT_WIDTH-1:0] evcnt_q,  evcnt_d;
    logic [31:0]          rdata_q,  rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 irq_q,    irq_d;

    reg_sel_e    sel;
    logic        wr;
    logic        rd;
    logic        warm_done;
    logic [7:0]  rise;
    logic [7:0]  clr;
    logic [31:0] rd_mux;
    logic        addr_lsb_unused;

    assign Hit             = (Address[31:4] == BASE_ADDR[31:4]);
    assign sel             = reg_sel_e'(Address[3:2]);
    assign addr_lsb_unused = ^Address[1:0];

    // A simultaneous read and write is treated as a write only.
    assign wr = MemWrite & Hit;
    assign rd = MemRead & Hit & ~MemWrite;

    assign warm_done = (warm_q == 2'd2);
    assign rise      = warm_done ? (sync2_q & ~prev_q) : 8'h00;

    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        out_d    = out_q;
        en_d     = en_q;
        evcnt_d  = evcnt_q;
        warm_d   = warm_q;
        clr      = 8'h00;
        rd_mux   = 32'h0;
        rvalid_d = rd;
        rdata_d  = rdata_q;

        if (!warm_done) begin
            warm_d = warm_q + 2'd1;
        end

        // During warm-up prev is preloaded with the value sync2 is about to
        // take, so a level already present at reset release is the baseline
        // rather than a rise.
        prev_d = warm_done ? sync2_q : sync1_q;

        if (wr && sel == REG_OUT) begin
            out_d = WriteData;
        end
        if (wr && sel == REG_EDGE) begin
            clr  = WriteData[7:0];
            en_d = WriteData[15:8];
        end

        // A new rise beats a W1C on the same bit.
        edge_d = rise | (edge_q & ~clr);

        if (wr && sel == REG_EVCNT) begin
            evcnt_d = '0;
        end else if (|(rise & en_q) && !(&evcnt_q)) begin
            evcnt_d = evcnt_q + CNT_WIDTH'(1);
        end

        // Registered from next-state values so the IRQ rises together with
        // the flag becoming visible.
        irq_d = |(edge_d & en_d);

        unique case (sel)
            REG_OUT:   rd_mux = out_q;
            REG_IN:    rd_mux = {24'h0, sync2_q};
            REG_EDGE:  rd_mux = {16'h0, en_q, edge_q};
            REG_EVCNT: rd_mux = 32'(evcnt_q);
            default:   rd_mux = 32'h0;
        endcase

        if (rd) begin
            rdata_d = rd_mux;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            warm_q   <= '0;
            edge_q   <= '0;
            en_q     <= '0;
            evcnt_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            sync1_q  <= PortIn;
            sync2_q  <= sync1_q;
            prev_q   <= prev_d;
            warm_q   <= warm_d;
            edge_q   <= edge_d;
            en_q     <= en_d;
            evcnt_q  <= evcnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign PortOut   = out_q;
    assign ReadData  = rdata_q;
    assign ReadValid = rvalid_q;
    assign EdgeIrq   = irq_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// -----------------------------------------------------------------------------
// tb_mmio_port_responder
//
// Self-checking bench for mmio_port_responder. A behavioural model tracks the
// register file from the register-map rules, using a short history of sampled
// PortIn values to decide when a rise becomes visible. Directed scenarios use
// literal expectations; the random scenario compares against the model.
// -----------------------------------------------------------------------------
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic [31:0] Address   = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        MemWrite  = 1'b0;
    logic        MemRead   = 1'b0;
    logic [7:0]  PortIn    = 8'h00;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        Hit;
    logic [31:0] PortOut;
    logic        EdgeIrq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rd_data;
    logic        rd_valid;

    mmio_port_responder #(
        .BASE_ADDR(BASE),
        .CNT_WIDTH(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData),
        .ReadValid(ReadValid),
        .Hit      (Hit),
        .PortIn   (PortIn),
        .PortOut  (PortOut),
        .EdgeIrq  (EdgeIrq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_out, m_rdata;
    logic [7:0]  m_edge, m_en;
    logic [15:0] m_cnt;
    logic        m_rvalid, m_irq;
    logic [7:0]  h0, h1, h2, h3;   // PortIn sampled at the last four edges
    int          m_age;            // edges since reset, capped at 4

    always @(posedge clk) begin : model_proc
        logic [7:0]  m_rise;
        logic [7:0]  m_clr;
        logic [31:0] m_rv;
        logic        m_hit, m_wr, m_rd;
        logic [1:0]  m_off;
        if (!reset) begin
            m_out = 0; m_rdata = 0; m_edge = 0; m_en = 0; m_cnt = 0;
            m_rvalid = 0; m_irq = 0; h0 = 0; h1 = 0; h2 = 0; h3 = 0; m_age = 0;
        end else begin
            h3 = h2; h2 = h1; h1 = h0; h0 = PortIn;
            if (m_age < 4) m_age++;
            // A change sampled at edge n is seen at edge n+2; the level at the
            // first post-reset sample is the baseline.
            m_rise = (m_age >= 4) ? (h2 & ~h3) : 8'h00;
            m_hit  = (Address[31:4] == BASE[31:4]);
            m_off  = Address[3:2];
            m_wr   = MemWrite && m_hit;
            m_rd   = MemRead && m_hit && !MemWrite;
            case (m_off)
                2'd0:    m_rv = m_out;
                2'd1:    m_rv = {24'h0, h2};
                2'd2:    m_rv = {16'h0, m_en, m_edge};
                default: m_rv = {16'h0, m_cnt};
            endcase
            m_rvalid = m_rd;
            if (m_rd) m_rdata = m_rv;
            m_clr = (m_wr && m_off == 2'd2) ? WriteData[7:0] : 8'h00;
            if (m_wr && m_off == 2'd3) m_cnt = 0;
            else if ((m_rise & m_en) != 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            if (m_wr && m_off == 2'd0) m_out = WriteData;
            m_edge = m_rise | (m_edge & ~m_clr);
            if (m_wr && m_off == 2'd2) m_en = WriteData[15:8];
            m_irq = ((m_edge & m_en) != 0);
        end
    end

    // ---------------- bus drivers (called at a negedge) ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        Address = a; MemRead = 1'b1; MemWrite = 1'b0;
        @(negedge clk);
        MemRead = 1'b0;
        d = ReadData;
        v = ReadValid;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        PortIn = 8'hFF; reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (PortOut !== 32'h0) $display("FAIL reset_portout: got %h want %h", PortOut, 32'h0); else n_pass++;
            n_checks++; if (EdgeIrq !== 1'b0) $display("FAIL reset_irq: got %b want 0", EdgeIrq); else n_pass++;
        end
        bus_read(BASE + 32'h8, rd_data, rd_valid);
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL reset_edge_valid: got %b want 1", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_edge: got %h want %h", rd_data, 32'h0); else n_pass++;
        bus_read(BASE + 32'hC, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_evcnt: got %h want %h", rd_data, 32'h0); else n_pass++;
    endtask

    task automatic test_write_read();
        bus_write(BASE, 32'hDEAD_BEEF);
        n_checks++; if (PortOut !== 32'hDEAD_BEEF) $display("FAIL wr_portout: got %h want %h", PortOut, 32'hDEAD_BEEF); else n_pass++;
        bus_read(BASE, rd_data, rd_valid);
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL rd_valid: got %b want 1", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 32'hDEAD_BEEF) $display("FAIL rd_out: got %h want %h", rd_data, 32'hDEAD_BEEF); else n_pass++;
        @(negedge clk);
        n_checks++; if (ReadValid !== 1'b0) $display("FAIL rd_single_pulse: got %b want 0", ReadValid); else n_pass++;
        n_checks++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL rd_hold: got %h want %h", ReadData, 32'hDEAD_BEEF); else n_pass++;
    endtask

    task automatic test_edge_flags();
        PortIn = 8'h00;
        repeat (4) @(negedge clk);
        bus_write(BASE + 32'h8, 32'h0000_0100);
        PortIn = 8'h05;
        @(negedge clk);
        n_checks++; if (EdgeIrq !== 1'b0) $display("FAIL edge_irq_early1: got %b want 0", EdgeIrq); else n_pass++;
        @(negedge clk);
        n_checks++; if (EdgeIrq !== 1'b0) $display("FAIL edge_irq_early2: got %b want 0", EdgeIrq); else n_pass++;
        @(negedge clk);
        n_checks++; if (EdgeIrq !== 1'b1) $display("FAIL edge_irq_set: got %b want 1", EdgeIrq); else n_pass++;
        bus_read(BASE + 32'h8, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0000_0105) $display("FAIL edge_flags: got %h want %h", rd_data, 32'h0000_0105); else n_pass++;
        bus_read(BASE + 32'hC, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h1) $display("FAIL edge_evcnt: got %h want %h", rd_data, 32'h1); else n_pass++;
        bus_write(BASE + 32'h8, 32'h0000_0104);
        bus_read(BASE + 32'h8, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0000_0101) $display("FAIL w1c_bit2: got %h want %h", rd_data, 32'h0000_0101); else n_pass++;
        n_checks++; if (EdgeIrq !== 1'b1) $display("FAIL w1c_bit2_irq: got %b want 1", EdgeIrq); else n_pass++;
        bus_write(BASE + 32'h8, 32'h0000_0101);
        bus_read(BASE + 32'h8, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0000_0100) $display("FAIL w1c_bit0: got %h want %h", rd_data, 32'h0000_0100); else n_pass++;
        n_checks++; if (EdgeIrq !== 1'b0) $display("FAIL w1c_bit0_irq: got %b want 0", EdgeIrq); else n_pass++;
    endtask

    task automatic test_w1c_collision();
        // Read in the cycle the flag is being set returns the old value.
        PortIn = 8'h04;
        repeat (4) @(negedge clk);
        PortIn = 8'h05;
        @(negedge clk); @(negedge clk);
        bus_read(BASE + 32'h8, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0000_0100) $display("FAIL rd_before_set: got %h want %h", rd_data, 32'h0000_0100); else n_pass++;
        bus_read(BASE + 32'h8, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0000_0101) $display("FAIL rd_after_set: got %h want %h", rd_data, 32'h0000_0101); else n_pass++;
        // W1C of bit0 on the same edge as a new rise on bit0.
        PortIn = 8'h04;
        repeat (4) @(negedge clk);
        PortIn = 8'h05;
        @(negedge clk); @(negedge clk);
        bus_write(BASE + 32'h8, 32'h0000_0101);
        bus_read(BASE + 32'h8, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0000_0101) $display("FAIL set_wins_w1c: got %h want %h", rd_data, 32'h0000_0101); else n_pass++;
        n_checks++; if (EdgeIrq !== 1'b1) $display("FAIL set_wins_irq: got %b want 1", EdgeIrq); else n_pass++;
        bus_read(BASE + 32'hC, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h3) $display("FAIL collision_evcnt: got %h want %h", rd_data, 32'h3); else n_pass++;
    endtask

    task automatic test_evcnt_saturation();
        force dut.evcnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.evcnt_q;
        for (int i = 0; i < 3; i++) begin
            PortIn = 8'h04; repeat (3) @(negedge clk);
            PortIn = 8'h05; repeat (3) @(negedge clk);
        end
        bus_read(BASE + 32'hC, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0000_FFFF) $display("FAIL evcnt_saturate: got %h want %h", rd_data, 32'h0000_FFFF); else n_pass++;
        bus_write(BASE + 32'hC, 32'h1234_0000);
        bus_read(BASE + 32'hC, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL evcnt_clear: got %h want %h", rd_data, 32'h0); else n_pass++;
    endtask

    task automatic test_miss();
        Address = BASE - 32'h4; #1;
        n_checks++; if (Hit !== 1'b0) $display("FAIL hit_below: got %b want 0", Hit); else n_pass++;
        Address = BASE + 32'hC; #1;
        n_checks++; if (Hit !== 1'b1) $display("FAIL hit_top: got %b want 1", Hit); else n_pass++;
        Address = BASE + 32'h10; WriteData = 32'h5555_5555; MemWrite = 1'b1; MemRead = 1'b1; #1;
        n_checks++; if (Hit !== 1'b0) $display("FAIL hit_above: got %b want 0", Hit); else n_pass++;
        @(negedge clk);
        MemWrite = 1'b0;
        @(negedge clk);
        MemRead = 1'b0;
        n_checks++; if (ReadValid !== 1'b0) $display("FAIL miss_valid: got %b want 0", ReadValid); else n_pass++;
        n_checks++; if (PortOut !== 32'hDEAD_BEEF) $display("FAIL miss_portout: got %h want %h", PortOut, 32'hDEAD_BEEF); else n_pass++;
        bus_write(BASE + 32'h18, 32'h0000_FF00);
        bus_read(BASE + 32'h8, rd_data, rd_valid);
        n_checks++; if (rd_data !== 32'h0000_0101) $display("FAIL miss_edge_unchanged: got %h want %h", rd_data, 32'h0000_0101); else n_pass++;
    endtask

    task automatic test_read_write_same();
        Address = BASE; WriteData = 32'h1234_5678; MemWrite = 1'b1; MemRead = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b0;
        n_checks++; if (PortOut !== 32'h1234_5678) $display("FAIL rw_portout: got %h want %h", PortOut, 32'h1234_5678); else n_pass++;
        n_checks++; if (ReadValid !== 1'b0) $display("FAIL rw_no_valid: got %b want 0", ReadValid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        MemRead = 1'b1; Address = BASE;
        @(negedge clk);
        n_checks++; if (ReadValid !== 1'b1 || ReadData !== 32'h1234_5678) $display("FAIL b2b_0: got %b/%h want 1/%h", ReadValid, ReadData, 32'h1234_5678); else n_pass++;
        Address = BASE + 32'h4;
        @(negedge clk);
        n_checks++; if (ReadValid !== 1'b1 || ReadData !== 32'h0000_0005) $display("FAIL b2b_1: got %b/%h want 1/%h", ReadValid, ReadData, 32'h0000_0005); else n_pass++;
        Address = BASE + 32'h8;
        @(negedge clk);
        MemRead = 1'b0;
        n_checks++; if (ReadValid !== 1'b1 || ReadData !== 32'h0000_0101) $display("FAIL b2b_2: got %b/%h want 1/%h", ReadValid, ReadData, 32'h0000_0101); else n_pass++;
        @(negedge clk);
        n_checks++; if (ReadValid !== 1'b0) $display("FAIL b2b_end: got %b want 0", ReadValid); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        Address = BASE; MemRead = 1'b1; reset = 1'b0;
        @(negedge clk);
        MemRead = 1'b0;
        n_checks++; if (ReadValid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", ReadValid); else n_pass++;
        n_checks++; if (ReadData !== 32'h0) $display("FAIL mid_reset_rdata: got %h want %h", ReadData, 32'h0); else n_pass++;
        n_checks++; if (PortOut !== 32'h0) $display("FAIL mid_reset_portout: got %h want %h", PortOut, 32'h0); else n_pass++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (EdgeIrq !== 1'b0) $display("FAIL mid_reset_irq: got %b want 0", EdgeIrq); else n_pass++;
    endtask

    task automatic test_random();
        logic exp_hit;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) PortIn = 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                Address = BASE ^ (32'h10 << $urandom_range(0, 27));
            else
                Address = BASE + {28'h0, 2'($urandom), 2'($urandom)};
            WriteData = $urandom;
            MemWrite  = ($urandom_range(0, 3) == 0);
            MemRead   = ($urandom_range(0, 1) == 0);
            exp_hit   = (Address[31:4] == BASE[31:4]);
            #1;
            n_checks++; if (Hit !== exp_hit) $display("FAIL rnd_hit[%0d]: got %b want %b", i, Hit, exp_hit); else n_pass++;
            @(negedge clk);
            n_checks++; if (ReadValid !== m_rvalid) $display("FAIL rnd_valid[%0d]: got %b want %b", i, ReadValid, m_rvalid); else n_pass++;
            n_checks++; if (ReadData !== m_rdata) $display("FAIL rnd_rdata[%0d]: got %h want %h", i, ReadData, m_rdata); else n_pass++;
            n_checks++; if (PortOut !== m_out) $display("FAIL rnd_portout[%0d]: got %h want %h", i, PortOut, m_out); else n_pass++;
            n_checks++; if (EdgeIrq !== m_irq) $display("FAIL rnd_irq[%0d]: got %b want %b", i, EdgeIrq, m_irq); else n_pass++;
        end
        MemWrite = 1'b0; MemRead = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_edge_flags();
        test_w1c_collision();
        test_evcnt_saturation();
        test_miss();
        test_read_write_same();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
